// File: rtl/alu_seq_ctrl.sv
// Sequencer for a bus-based ALU datapath: captures operands, steps them onto the shared bus,
// waits for the ALU to settle, strobes the result register and pulses done.
`timescale 1ns/1ps
module alu_seq_ctrl #(
  parameter int WIDTH       = 32,
  parameter int OPW         = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clk_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [OPW-1:0]   op_in,
  output logic [WIDTH-1:0] data_bus,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_f,
  output logic [OPW-1:0]   alu_op,
  output logic             busy,
  output logic             done,
  output logic [7:0]       op_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [3:0]       wait_q, wait_d;
  logic [7:0]       cnt_q, cnt_d;

  // Next-state logic; abort outranks everything, including an accept in IDLE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            a_d     = a_in;
            b_d     = b_in;
            op_d    = op_in;
            state_d = S_LOAD_A;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD_A: state_d = S_LOAD_B;
        S_LOAD_B: begin
          state_d = S_EXEC;
          wait_d  = 4'd0;
        end
        S_EXEC: begin
          if (wait_q == EXEC_LAST) begin
            state_d = S_WRITE;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
        S_WRITE: state_d = S_DONE;
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 8'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge clk_rst) begin
    if (!clk_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      wait_q  <= 4'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    data_bus = '0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_f     = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_LOAD_A: begin
        data_bus = a_q;
        ld_a     = 1'b1;
      end
      S_LOAD_B: begin
        data_bus = b_q;
        ld_b     = 1'b1;
      end
      S_EXEC:   busy = 1'b1;
      S_WRITE:  ld_f = 1'b1;
      S_DONE:   done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  assign alu_op = op_q;
  assign op_cnt = cnt_q;

endmodule
